tilemap_loader: RTL and testbench

//  Writer side of the 15x20 background tile map that the colour mapper indexes with

---
 rtl/tilemap_loader_if.sv | 26 ++
 rtl/tilemap_loader.sv | 156 +++++++++++++++
 tb/tb_tilemap_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tilemap_loader_if.sv
// Connects the scroll/level controller, level ROM and colour mapper to the tile map writer.
interface tilemap_loader_if #(parameter int TILE_W = 2);
   logic              vblank;
   logic              load_req;
   logic [4:0]        load_col;
   logic [7:0]        src_col;
   logic              clear_req;
   logic              busy;
   logic              done;
   logic              err;
   logic [11:0]       rom_addr;
   logic [TILE_W-1:0] rom_data;
   logic [3:0]        rd_row;
   logic [4:0]        rd_col;
   logic [TILE_W-1:0] rd_tile;

   modport master (
      output vblank, load_req, load_col, src_col, clear_req, rom_data, rd_row, rd_col,
      input  busy, done, err, rom_addr, rd_tile
   );

   modport slave (
      input  vblank, load_req, load_col, src_col, clear_req, rom_data, rd_row, rd_col,
      output busy, done, err, rom_addr, rd_tile
   );
endinterface

// File: rtl/tilemap_loader.sv
// Background tile map writer: loads one screen column from the level ROM or clears the map
// during vblank, and feeds the colour mapper through a registered read port.
//
// state   | meaning
// S_IDLE  | waiting for clear_req / load_req
// S_LOAD  | issuing one ROM read per vblank cycle, writing returned codes a cycle later
// S_CLEAR | clearing one full map row per vblank cycle
// S_FIN   | one-cycle done pulse, row counter rewinds
module tilemap_loader #(
   parameter int                ROWS       = 15,
   parameter int                COLS       = 20,
   parameter int                TILE_W     = 2,
   parameter int                LEVEL_COLS = 256,
   parameter logic [TILE_W-1:0] CLEAR_TILE = '0
) (
   input logic             Clk,
   input logic             Reset,
   tilemap_loader_if.slave bus
);
   localparam int               ROW_W    = 4;
   localparam int               COL_W    = 5;
   localparam logic [7:0]       SRC_MASK = 8'(LEVEL_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROWS);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_END  = COL_W'(COLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_FIN
   } state_t;

   state_t             state_q;
   state_t             state_n;
   logic [ROW_W-1:0]   row_q;
   logic               pend_q;
   logic [ROW_W-1:0]   pend_row_q;
   logic [COL_W-1:0]   col_q;
   logic [7:0]         src_q;
   logic [TILE_W-1:0]  map_q [ROWS][COLS];
   logic [TILE_W-1:0]  rd_tile_q;

   logic               issue;
   logic               clr_row;
   logic               accept_load;
   logic               busy;
   logic               done;
   logic               err;
   logic               rd_in_map;
   logic [11:0]        rom_addr_c;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      busy        = 1'b1;
      done        = 1'b0;
      err         = 1'b0;
      issue       = 1'b0;
      clr_row     = 1'b0;
      accept_load = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (bus.clear_req) begin
               state_n = S_CLEAR;
            end else if (bus.load_req) begin
               if (bus.load_col < COL_END) begin
                  accept_load = 1'b1;
                  state_n     = S_LOAD;
               end else begin
                  err = 1'b1;
               end
            end
         end
         S_LOAD: begin
            // all rows issued: the only read still in flight lands this cycle
            if (row_q == ROW_END) begin
               state_n = S_FIN;
            end else if (bus.vblank) begin
               issue = 1'b1;
            end
         end
         S_CLEAR: begin
            if (bus.vblank) begin
               clr_row = 1'b1;
               if (row_q == ROW_LAST) begin
                  state_n = S_FIN;
               end
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign rom_addr_c = 12'(src_q & SRC_MASK) * 12'(ROWS) + 12'(row_q);
   assign rd_in_map  = (bus.rd_row < ROW_END) && (bus.rd_col < COL_END);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         row_q      <= '0;
         pend_q     <= 1'b0;
         pend_row_q <= '0;
         col_q      <= '0;
         src_q      <= '0;
         rd_tile_q  <= CLEAR_TILE;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               map_q[r][c] <= CLEAR_TILE;
            end
         end
      end else begin
         if (accept_load) begin
            col_q <= bus.load_col;
            src_q <= bus.src_col;
         end
         if (issue || clr_row) begin
            row_q <= row_q + 1'b1;
         end else if (state_q == S_FIN) begin
            row_q <= '0;
         end
         pend_q <= issue;
         if (issue) begin
            pend_row_q <= row_q;
         end
         if (pend_q) begin
            map_q[pend_row_q][col_q] <= bus.rom_data;
         end
         if (clr_row) begin
            for (int c = 0; c < COLS; c++) begin
               map_q[row_q][c] <= CLEAR_TILE;
            end
         end
         // same-cycle read of a cell being written sees the old code
         rd_tile_q <= rd_in_map ? map_q[bus.rd_row][bus.rd_col] : CLEAR_TILE;
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.err      = err;
   assign bus.rom_addr = issue ? rom_addr_c : '0;
   assign bus.rd_tile  = rd_tile_q;

endmodule

// File: tb/tb_tilemap_loader.sv
// Randomized bench for tilemap_loader: a cell-level map model plus per-operation schedules
// derived from the vblank pattern predict busy/done/err/rom_addr/rd_tile every cycle.
module tb_tilemap_loader;
   localparam int         ROWS = 15;
   localparam int         COLS = 20;
   localparam logic [1:0] CLR  = 2'd0;
   localparam int         MAXT = 80;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tilemap_loader_if #(.TILE_W(2)) bus ();

   tilemap_loader #(
      .ROWS(ROWS), .COLS(COLS), .TILE_W(2), .LEVEL_COLS(256), .CLEAR_TILE(CLR)
   ) dut (
      .Clk(clk),
      .Reset(reset),
      .bus(bus)
   );

   int          checks = 0;
   int          failures = 0;
   int          rom_mode = 0;
   logic [1:0]  mdl [ROWS][COLS];
   logic        vb [0:MAXT];
   int          slot [ROWS];

   logic        chk_en = 1'b0;
   logic        chk_addr = 1'b0;
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_err = 1'b0;
   logic [11:0] exp_addr = '0;
   logic [1:0]  exp_rd = CLR;
   logic [1:0]  saved_rd = CLR;
   logic        pin_en = 1'b0;
   string       pin_name = "";
   int          pin_act = 0;
   int          pin_want = 0;

   logic        upd_rst = 1'b0;
   logic        upd_wr = 1'b0;
   logic        upd_clr = 1'b0;
   int          upd_row = 0;
   int          upd_col = 0;
   int          upd_clr_row = 0;
   logic [1:0]  upd_val = '0;

   function automatic logic [1:0] rom_f(int a);
      if (rom_mode == 0) return 2'(a % 4);
      return 2'((a * 7 + a / 5) % 4);
   endfunction

   // synchronous level ROM: data follows the address by one cycle
   always @(posedge clk) bus.rom_data <= rom_f(int'(bus.rom_addr));

   function automatic logic [1:0] look(int r, int c);
      if (r < ROWS && c < COLS) return mdl[r][c];
      return CLR;
   endfunction

   task automatic cmp(string n, int act, int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at time %0t", n, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("busy", int'(bus.busy), int'(exp_busy));
         cmp("done", int'(bus.done), int'(exp_done));
         cmp("err", int'(bus.err), int'(exp_err));
         cmp("rd_tile", int'(bus.rd_tile), int'(exp_rd));
         if (chk_addr) cmp("rom_addr", int'(bus.rom_addr), int'(exp_addr));
      end
      if (pin_en) cmp(pin_name, pin_act, pin_want);
   end

   task automatic set_rd(int r, int c);
      bus.rd_row = 4'(r);
      bus.rd_col = 5'(c);
      saved_rd   = look(r, c);
   endtask

   task automatic begin_cycle();
      bus.vblank    = 1'($urandom_range(0, 1));
      bus.load_req  = 1'b0;
      bus.clear_req = 1'b0;
      bus.load_col  = 5'($urandom_range(0, 31));
      bus.src_col   = 8'($urandom);
      reset    = 1'b0;
      chk_addr = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      pin_en   = 1'b0;
      set_rd(int'($urandom_range(0, 15)), int'($urandom_range(0, 22)));
   endtask

   task automatic end_cycle();
      @(posedge clk);
      #1;
      if (upd_rst) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mdl[r][c] = CLR;
         exp_rd = CLR;
      end else begin
         exp_rd = saved_rd;
         if (upd_wr) mdl[upd_row][upd_col] = upd_val;
         if (upd_clr) for (int c = 0; c < COLS; c++) mdl[upd_clr_row][c] = CLR;
      end
      upd_rst = 1'b0;
      upd_wr  = 1'b0;
      upd_clr = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         begin_cycle();
         end_cycle();
      end
   endtask

   task automatic sweep();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            begin_cycle();
            set_rd(r, c);
            end_cycle();
         end
      end
      idle(1);
   endtask

   task automatic pin(string n, int a, int w);
      begin_cycle();
      pin_en   = 1'b1;
      pin_name = n;
      pin_act  = a;
      pin_want = w;
      end_cycle();
   endtask

   task automatic plan(int mode);
      int n;
      for (int t = 0; t <= MAXT; t++) begin
         case (mode)
            0:       vb[t] = 1'b1;
            1:       vb[t] = (t % 2 == 1);
            default: vb[t] = (t >= 60) || ($urandom_range(0, 9) < 6);
         endcase
      end
      n = 0;
      for (int t = 1; t <= MAXT; t++) begin
         if (vb[t] && n < ROWS) begin
            slot[n] = t;
            n++;
         end
      end
   endtask

   task automatic do_load(int col, logic [7:0] src, int mode, int abort_at, int hit_row,
                          output int d_cyc, output int first_addr);
      int base;
      base       = (int'(src) % 256) * ROWS;
      first_addr = base;
      plan(mode);
      begin_cycle();
      bus.load_req = 1'b1;
      bus.load_col = 5'(col);
      bus.src_col  = src;
      exp_err      = (col >= COLS);
      end_cycle();
      d_cyc = -1;
      if (col >= COLS) return;
      d_cyc = slot[ROWS-1] + 2;
      for (int t = 1; t <= d_cyc; t++) begin
         begin_cycle();
         bus.vblank    = vb[t];
         bus.load_req  = 1'($urandom_range(0, 1));
         bus.clear_req = ($urandom_range(0, 3) == 0);
         exp_busy      = 1'b1;
         exp_done      = (t == d_cyc);
         for (int k = 0; k < ROWS; k++) begin
            if (slot[k] == t) begin
               chk_addr = 1'b1;
               exp_addr = 12'(base + k);
            end
            if (slot[k] + 1 == t) begin
               upd_wr  = 1'b1;
               upd_row = k;
               upd_col = col;
               upd_val = rom_f(base + k);
            end
            if (k == hit_row && (slot[k] + 1 == t || slot[k] + 2 == t)) set_rd(k, col);
         end
         if (t == abort_at) begin
            reset   = 1'b1;
            upd_rst = 1'b1;
         end
         end_cycle();
         if (t == abort_at) return;
      end
   endtask

   task automatic do_clear(int mode, logic with_load, output int d_cyc);
      plan(mode);
      begin_cycle();
      bus.clear_req = 1'b1;
      bus.load_req  = with_load;
      end_cycle();
      d_cyc = slot[ROWS-1] + 1;
      for (int t = 1; t <= d_cyc; t++) begin
         begin_cycle();
         bus.vblank    = vb[t];
         bus.load_req  = 1'($urandom_range(0, 1));
         bus.clear_req = ($urandom_range(0, 3) == 0);
         exp_busy      = 1'b1;
         exp_done      = (t == d_cyc);
         for (int k = 0; k < ROWS; k++) begin
            if (slot[k] == t) begin
               upd_clr     = 1'b1;
               upd_clr_row = k;
            end
         end
         end_cycle();
      end
   endtask

   initial begin
      int d;
      int fa;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         begin_cycle();
         reset   = 1'b1;
         upd_rst = 1'b1;
         end_cycle();
      end
      chk_en = 1'b1;
      begin_cycle();
      chk_addr = 1'b1;
      exp_addr = '0;
      end_cycle();
      sweep();

      rom_mode = 0;
      do_load(3, 8'd2, 0, -1, -1, d, fa);
      pin("t2_done_cycle", d, 17);
      pin("t2_first_addr", fa, 30);
      pin("t2_model_row0", int'(mdl[0][3]), 2);
      pin("t2_model_row14", int'(mdl[14][3]), 0);
      sweep();

      rom_mode = 1;
      do_load(3, 8'd2, 1, -1, -1, d, fa);
      pin("t3_done_cycle", d, 31);
      sweep();

      do_load(20, 8'd9, 0, -1, -1, d, fa);
      idle(2);
      do_load(27, 8'd1, 0, -1, -1, d, fa);
      do_clear(0, 1'b1, d);
      pin("t4_clear_done_cycle", d, 16);
      sweep();

      rom_mode = 0;
      do_load(4, 8'd2, 0, 8, -1, d, fa);
      idle(2);
      sweep();
      do_load(6, 8'(260), 0, -1, -1, d, fa);
      pin("t5_wrap_first_addr", fa, 60);
      do_load(8, 8'd4, 2, -1, -1, d, fa);

      do_load(7, 8'd2, 0, -1, 5, d, fa);
      pin("t6_model_row5", int'(mdl[5][7]), 3);
      sweep();

      for (int i = 0; i < 14; i++) begin
         rom_mode = int'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) do_clear(2, 1'($urandom_range(0, 1)), d);
         else do_load(int'($urandom_range(0, 22)), 8'($urandom), 2, -1, -1, d, fa);
         idle(int'($urandom_range(0, 3)));
      end
      sweep();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
